lsu_mem_master: RTL and testbench

- Initiator side of the single-outstanding mem request/response interface served by the SoC memory bus.
- Accepts load/store ops from the LSU and drives mem_mstReq_valid/mem_addr/mem_data_w/mem_wstrb; waits for mem_slvRsp_valid.
- Returns sign/zero-extended load data or store completion to the LSU with a tag.
- Rejects illegal regions and handles flush and response timeout.

---
 rtl/lsu_mem_master_pkg.sv | 57 +++++
 rtl/lsu_load_extend.sv | 34 +++
 rtl/lsu_mem_master.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_master_pkg.sv
// ============================================================================
//  Module      : lsu_mem_master_pkg
//  Description : Shared op-field layout, region map, FSM states and strobe
//                helpers for the LSU memory master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_mem_master_pkg;

    localparam int c_op_size_lo = 0;
    localparam int c_op_uns_bit = 2;
    localparam int c_op_wr_bit  = 3;

    localparam logic [1:0] c_size_b = 2'd0;
    localparam logic [1:0] c_size_h = 2'd1;
    localparam logic [1:0] c_size_w = 2'd2;
    localparam logic [1:0] c_size_d = 2'd3;

    localparam logic [35:0] c_region_sram = 36'h8;
    localparam logic [35:0] c_region_axi  = 36'h9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic [7:0] size_wstrb(input logic [1:0] size);
        logic [7:0] strb;
        case (size)
            c_size_b: strb = 8'h01;
            c_size_h: strb = 8'h03;
            c_size_w: strb = 8'h0F;
            default:  strb = 8'hFF;
        endcase
        return strb;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            c_size_b: mask = 64'h0000_0000_0000_00FF;
            c_size_h: mask = 64'h0000_0000_0000_FFFF;
            c_size_w: mask = 64'h0000_0000_FFFF_FFFF;
            default:  mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

    function automatic logic region_ok(input logic [63:0] addr);
        return (addr[63:28] == c_region_sram) || (addr[63:28] == c_region_axi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_extend.sv
// ============================================================================
//  Module      : lsu_load_extend
//  Description : Selects the low B/H/W/D bytes of read data and sign- or
//                zero-extends them to 64 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_extend
    import lsu_mem_master_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [63:0] data_o
);

    logic [63:0] w_data;

    always_comb begin
        w_data = data_i;
        case (size_i)
            c_size_b: w_data = {{56{!uns_i && data_i[7]}},  data_i[7:0]};
            c_size_h: w_data = {{48{!uns_i && data_i[15]}}, data_i[15:0]};
            c_size_w: w_data = {{32{!uns_i && data_i[31]}}, data_i[31:0]};
            default:  w_data = data_i;
        endcase
    end

    assign data_o = w_data;

endmodule

`default_nettype wire

// File: rtl/lsu_mem_master.sv
// ============================================================================
//  Module      : lsu_mem_master
//  Description : Single-outstanding initiator bridging LSU load/store ops onto
//                the SoC mem request/response bus, with region check,
//                flush suppression and response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             lsu_req_valid,
    output logic             lsu_req_ready,
    input  logic [3:0]       lsu_req_op,
    input  logic [63:0]      lsu_req_addr,
    input  logic [63:0]      lsu_req_data,
    input  logic [TAG_W-1:0] lsu_req_tag,
    input  logic             flush,
    output logic             lsu_rsp_valid,
    output logic [63:0]      lsu_rsp_data,
    output logic [TAG_W-1:0] lsu_rsp_tag,
    output logic             lsu_rsp_fault,
    output logic             mem_mstReq_valid,
    output logic [63:0]      mem_addr,
    output logic [63:0]      mem_data_w,
    output logic [7:0]       mem_wstrb,
    input  logic [63:0]      mem_data_r,
    input  logic             mem_slvRsp_valid
);

    localparam int             CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               rdy_en_q;
    logic [63:0]        addr_q, data_q;
    logic [3:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_fault_q, rsp_fault_d;
    logic               rsp_illegal_q, rsp_illegal_d;
    logic [63:0]        rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

    logic               w_accept, w_legal, w_in_req, w_wr, w_uns, w_suppress, w_kill_illegal;
    logic [1:0]         w_size;
    logic [63:0]        w_load_data;

    assign w_accept   = lsu_req_valid && lsu_req_ready;
    assign w_legal    = region_ok(lsu_req_addr);
    assign w_in_req   = (state_q == ST_REQ);
    assign w_wr       = op_q[c_op_wr_bit];
    assign w_uns      = op_q[c_op_uns_bit];
    assign w_size     = op_q[c_op_size_lo +: 2];
    assign w_suppress = flush || flush_pend_q;

    lsu_load_extend u_load_extend (
        .data_i (mem_data_r),
        .size_i (w_size),
        .uns_i  (w_uns),
        .data_o (w_load_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_pend_d  = flush_pend_q;
        rsp_valid_d   = 1'b0;
        rsp_fault_d   = 1'b0;
        rsp_illegal_d = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                cnt_d        = '0;
                if (w_accept) begin
                    if (w_legal) begin
                        state_d = ST_REQ;
                    end else begin
                        rsp_valid_d   = 1'b1;
                        rsp_fault_d   = 1'b1;
                        rsp_illegal_d = 1'b1;
                        rsp_data_d    = '0;
                        rsp_tag_d     = lsu_req_tag;
                    end
                end
            end
            ST_REQ: begin
                if (flush) flush_pend_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_slvRsp_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!w_suppress) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = w_wr ? 64'd0 : w_load_data;
                        rsp_tag_d   = tag_q;
                    end
                end else if (cnt_q == c_cnt_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!w_suppress) begin
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_tag_d   = tag_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_IDLE;
            rdy_en_q      <= 1'b0;
            cnt_q         <= '0;
            flush_pend_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
        end else begin
            state_q       <= state_d;
            rdy_en_q      <= 1'b1;
            cnt_q         <= cnt_d;
            flush_pend_q  <= flush_pend_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            addr_q <= '0;
            data_q <= '0;
            op_q   <= '0;
            tag_q  <= '0;
        end else if (w_accept) begin
            addr_q <= lsu_req_addr;
            data_q <= lsu_req_data;
            op_q   <= lsu_req_op;
            tag_q  <= lsu_req_tag;
        end
    end

    // Region faults are issued straight from IDLE, so a flush arriving in
    // the issue cycle can only be honoured by masking the registered pulse.
    assign w_kill_illegal = rsp_illegal_q && flush;

    assign lsu_req_ready    = rdy_en_q && (state_q == ST_IDLE) && !flush;
    assign lsu_rsp_valid    = rsp_valid_q && !w_kill_illegal;
    assign lsu_rsp_fault    = rsp_fault_q && !w_kill_illegal;
    assign lsu_rsp_data     = rsp_data_q;
    assign lsu_rsp_tag      = rsp_tag_q;

    // Address and write fields must read zero outside REQ: SRAM decodes from
    // the address alone and would otherwise see spurious writes.
    assign mem_mstReq_valid = w_in_req;
    assign mem_addr         = w_in_req ? addr_q : 64'd0;
    assign mem_wstrb        = (w_in_req && w_wr) ? size_wstrb(w_size) : 8'h00;
    assign mem_data_w       = (w_in_req && w_wr) ? (data_q & size_mask(w_size)) : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// ============================================================================
//  Module      : tb_lsu_mem_master
//  Description : Scoreboard bench for lsu_mem_master with a behavioural
//                reference model and a randomised memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_master;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 16;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             lsu_req_valid = 1'b0;
    logic             lsu_req_ready;
    logic [3:0]       lsu_req_op = '0;
    logic [63:0]      lsu_req_addr = '0;
    logic [63:0]      lsu_req_data = '0;
    logic [TAG_W-1:0] lsu_req_tag = '0;
    logic             flush = 1'b0;
    logic             lsu_rsp_valid;
    logic [63:0]      lsu_rsp_data;
    logic [TAG_W-1:0] lsu_rsp_tag;
    logic             lsu_rsp_fault;
    logic             mem_mstReq_valid;
    logic [63:0]      mem_addr;
    logic [63:0]      mem_data_w;
    logic [7:0]       mem_wstrb;
    logic [63:0]      mem_data_r = '0;
    logic             mem_slvRsp_valid = 1'b0;

    lsu_mem_master #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_op(lsu_req_op), .lsu_req_addr(lsu_req_addr),
        .lsu_req_data(lsu_req_data), .lsu_req_tag(lsu_req_tag),
        .flush(flush),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .lsu_rsp_tag(lsu_rsp_tag), .lsu_rsp_fault(lsu_rsp_fault),
        .mem_mstReq_valid(mem_mstReq_valid), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_wstrb(mem_wstrb),
        .mem_data_r(mem_data_r), .mem_slvRsp_valid(mem_slvRsp_valid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [63:0] data; logic fault; logic [TAG_W-1:0] tag; int cyc; } rsp_t;
    typedef struct { logic [63:0] addr; logic [7:0] wstrb; logic [63:0] wdata; int cyc; } req_t;
    typedef struct { logic write; logic [1:0] size; logic uns; logic [TAG_W-1:0] tag; logic supp; } op_t;

    rsp_t exp_rsp[$];
    req_t exp_req[$];
    op_t  pend_op[$];

    int checks = 0;
    int failures = 0;

    // Responder modes: 0 random, 1 fixed delay, 2 no response, 3 no response then stray, 4 silent
    int          resp_mode = 0;
    int          fix_d = 0;
    bit          resp_busy = 1'b0;
    bit          force_rd_en = 1'b0;
    logic [63:0] force_rd = '0;
    int          last_acc = 0;

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_m(input int size);
        int nbits;
        nbits = 8 << size;
        if (nbits >= 64) return '1;
        return (64'd1 << nbits) - 64'd1;
    endfunction

    function automatic logic [63:0] ext_m(input logic [63:0] raw, input int size, input bit uns);
        logic [63:0] v;
        int nbits;
        nbits = 8 << size;
        v = raw & mask_m(size);
        if (!uns && nbits < 64 && raw[nbits-1]) v = v | ~mask_m(size);
        return v;
    endfunction

    function automatic logic [7:0] wstrb_m(input int size);
        int nbytes;
        nbytes = 1 << size;
        return 8'((1 << nbytes) - 1);
    endfunction

    function automatic bit legal_m(input logic [63:0] a);
        return ((a >> 28) == 64'h8) || ((a >> 28) == 64'h9);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        rsp_t e;
        bit   prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                if (lsu_rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp actual tag=%h fault=%b required=no response", lsu_rsp_tag, lsu_rsp_fault);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_data", lsu_rsp_data, e.data);
                        chk("rsp_fault", 64'(lsu_rsp_fault), 64'(e.fault));
                        chk("rsp_tag", 64'(lsu_rsp_tag), 64'(e.tag));
                        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (mem_mstReq_valid) begin
                    chk("req_single_pulse", 64'(prev_req), 64'd0);
                end else begin
                    chk("idle_wstrb", 64'(mem_wstrb), 64'd0);
                    chk("idle_addr", mem_addr, 64'd0);
                    chk("idle_wdata", mem_data_w, 64'd0);
                end
            end
            prev_req = mem_mstReq_valid;
        end
    end

    // ---------------- memory responder / request checker ----------------
    initial begin : responder
        int          r, d;
        op_t         o;
        req_t        e;
        logic [63:0] rd;
        bit          tmo;
        forever begin
            @(negedge CLK);
            if (RSTn && mem_mstReq_valid) begin
                r = cyc;
                if (exp_req.size() == 0 || pend_op.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req actual addr=%h wstrb=%h required=no request", mem_addr, mem_wstrb);
                end else begin
                    resp_busy = 1'b1;
                    e = exp_req.pop_front();
                    o = pend_op.pop_front();
                    chk("req_addr", mem_addr, e.addr);
                    chk("req_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                    chk("req_wdata", mem_data_w, e.wdata);
                    chk("req_cycle", 64'(r), 64'(e.cyc));
                    tmo = (resp_mode == 2) || (resp_mode == 3) ||
                          (resp_mode == 0 && $urandom_range(0, 9) == 0);
                    if (resp_mode == 4) begin
                        tmo = 1'b0;
                    end else if (tmo) begin
                        if (!o.supp) exp_rsp.push_back('{data: 64'd0, fault: 1'b1, tag: o.tag, cyc: r + TIMEOUT + 1});
                        if (resp_mode == 3) begin
                            repeat (TIMEOUT + 4) @(posedge CLK);
                            #1;
                            mem_data_r = {$urandom, $urandom};
                            mem_slvRsp_valid = 1'b1;
                            @(posedge CLK); #1;
                            mem_slvRsp_valid = 1'b0;
                        end
                    end else begin
                        d = (resp_mode == 1) ? fix_d : $urandom_range(0, 6);
                        repeat (d + 1) @(posedge CLK);
                        #1;
                        rd = force_rd_en ? force_rd : {$urandom, $urandom};
                        mem_data_r = rd;
                        mem_slvRsp_valid = 1'b1;
                        if (!o.supp)
                            exp_rsp.push_back('{data: o.write ? 64'd0 : ext_m(rd, int'(o.size), o.uns),
                                                fault: 1'b0, tag: o.tag, cyc: r + 2 + d});
                        @(posedge CLK); #1;
                        mem_slvRsp_valid = 1'b0;
                    end
                    resp_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] data,
                         input logic [TAG_W-1:0] tag, input bit supp, input int flush_at);
        int  waitc;
        bit  got;
        @(posedge CLK); #1;
        lsu_req_valid = 1'b1;
        lsu_req_op    = op;
        lsu_req_addr  = addr;
        lsu_req_data  = data;
        lsu_req_tag   = tag;
        got = 1'b0;
        waitc = 0;
        while (!got && waitc < 200) begin
            @(negedge CLK);
            if (lsu_req_ready) got = 1'b1;
            else waitc++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout actual=not accepted required=accepted");
            lsu_req_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (legal_m(addr)) begin
            exp_req.push_back('{addr: addr, wstrb: op[3] ? wstrb_m(int'(op[1:0])) : 8'h00,
                                wdata: op[3] ? (data & mask_m(int'(op[1:0]))) : 64'd0, cyc: last_acc + 1});
            pend_op.push_back('{write: op[3], size: op[1:0], uns: op[2], tag: tag, supp: supp});
        end else if (!supp) begin
            exp_rsp.push_back('{data: 64'd0, fault: 1'b1, tag: tag, cyc: last_acc + 1});
        end
        @(posedge CLK); #1;
        lsu_req_valid = 1'b0;
        if (flush_at > 0) begin
            repeat (flush_at - 1) begin @(posedge CLK); #1; end
            flush = 1'b1;
            @(posedge CLK); #1;
            flush = 1'b0;
        end
    endtask

    task automatic drain(input int extra);
        int k;
        k = 0;
        while ((exp_rsp.size() != 0 || exp_req.size() != 0 || pend_op.size() != 0 || resp_busy) && k < 500) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (k >= 500) begin
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required=0", exp_rsp.size() + exp_req.size());
        end
        repeat (extra) @(negedge CLK);
    endtask

    task automatic at_cycle(input int t);
        @(negedge CLK);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tagname);
        chk({tagname, "_ready"}, 64'(lsu_req_ready), 64'd0);
        chk({tagname, "_rsp_valid"}, 64'(lsu_rsp_valid), 64'd0);
        chk({tagname, "_rsp_fault"}, 64'(lsu_rsp_fault), 64'd0);
        chk({tagname, "_rsp_data"}, lsu_rsp_data, 64'd0);
        chk({tagname, "_rsp_tag"}, 64'(lsu_rsp_tag), 64'd0);
        chk({tagname, "_req_valid"}, 64'(mem_mstReq_valid), 64'd0);
        chk({tagname, "_addr"}, mem_addr, 64'd0);
        chk({tagname, "_wdata"}, mem_data_w, 64'd0);
        chk({tagname, "_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=hung required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] a;
        int          sel;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);

        // Load W signed; sign bit set in the selected word
        force_rd_en = 1'b1;
        force_rd    = 64'h1122_3344_8000_00F0;
        resp_mode = 1; fix_d = 0;
        issue(4'b0010, 64'h8000_0104, 64'h0, 5'h11, 1'b0, 0);
        drain(1);
        force_rd_en = 1'b0;

        // Store H, unaligned
        fix_d = 1;
        issue(4'b1001, 64'h8000_0007, 64'hAAAA_BBBB_CCCC_DDDD, 5'h05, 1'b0, 0);
        drain(1);

        // Load BU outside legal regions
        issue(4'b0100, 64'h0000_1000, 64'h0, 5'h1A, 1'b0, 0);
        drain(1);

        // Load D timeout, then a stray response
        resp_mode = 3;
        issue(4'b0011, 64'h9000_0000, 64'h0, 5'h07, 1'b0, 0);
        drain(4);

        // Store with flush in REQ: bus write happens, LSU response suppressed
        resp_mode = 1; fix_d = 2;
        issue(4'b1010, 64'h8000_0100, 64'h1234_5678_9ABC_DEF0, 5'h0C, 1'b1, 1);
        at_cycle(last_acc + 3);
        chk("ready_in_wait", 64'(lsu_req_ready), 64'd0);
        at_cycle(last_acc + 5);
        chk("ready_after_rsp", 64'(lsu_req_ready), 64'd1);
        drain(1);

        // Flush while a request is offered in IDLE
        @(posedge CLK); #1;
        lsu_req_valid = 1'b1; lsu_req_op = 4'b0010; lsu_req_addr = 64'h8000_0200; flush = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("ready_under_flush", 64'(lsu_req_ready), 64'd0);
        end
        @(posedge CLK); #1;
        lsu_req_valid = 1'b0; flush = 1'b0;
        drain(3);

        // Flush coincident with the bus response
        fix_d = 1;
        issue(4'b0001, 64'h9000_0010, 64'h0, 5'h13, 1'b1, 3);
        drain(2);

        // Flush in the issue cycle of a region fault
        issue(4'b0000, 64'h4000_0000, 64'h0, 5'h14, 1'b1, 1);
        drain(2);

        // Asynchronous reset while waiting on the bus
        resp_mode = 4;
        issue(4'b0011, 64'h8000_0040, 64'h0, 5'h1F, 1'b0, 0);
        at_cycle(last_acc + 4);
        #1;
        RSTn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge CLK); @(posedge CLK); #1;
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);
        resp_mode = 1; fix_d = 0;
        issue(4'b0110, 64'h8000_0044, 64'h0, 5'h02, 1'b0, 0);
        drain(1);

        // Randomised traffic
        resp_mode = 0;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            a = {32'h0, $urandom};
            a[63:28] = (sel < 5) ? 36'h8 : (sel < 9) ? 36'h9 : {4'h0, $urandom};
            issue(4'($urandom_range(0, 15)), a, {$urandom, $urandom}, TAG_W'($urandom), 1'b0, 0);
        end
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
